// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: Mealy stall/flush strobes for load-use, EX redirects
// and data-memory waits, plus sticky timeout flag and saturating perf counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_RUN      | normal flow; load-use bubbles inserted without leaving RUN
// S_REDIRECT | IF/ID held flushed while the redirected fetch is in flight
// S_MEM_WAIT | whole pipe frozen until data memory completes or times out
module hazard_sequencer #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             redirect_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clear,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0]       RDR_LOAD   = 3'(REDIRECT_CYCLES);
  localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic [2:0] rdr_q, rdr_d;
  logic [7:0] wait_q, wait_d;
  logic       load_use, mem_wait;
  logic       flush_inc, timeout_set;

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = memread_ex && (rd_ex != 5'd0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) ||
                     (use_rs2_id && (rs2_id == rd_ex)));

  always_comb begin
    state_d     = state_q;
    rdr_d       = rdr_q;
    wait_d      = wait_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    flush_inc   = 1'b0;
    timeout_set = 1'b0;

    if (!rst) begin
      case (state_q)
        S_RUN, S_REDIRECT: begin
          if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_d     = S_MEM_WAIT;
            wait_d      = 8'd1;
            rdr_d       = 3'd0;
          end else if (redirect_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            if (RDR_LOAD != 3'd0) begin
              state_d = S_REDIRECT;
              rdr_d   = RDR_LOAD;
            end else begin
              state_d = S_RUN;
            end
          end else if (state_q == S_REDIRECT) begin
            ifid_flush = 1'b1;
            // The last remaining redirect cycle is consumed on the same edge we leave.
            if (rdr_q <= 3'd1) begin
              state_d = S_RUN;
              rdr_d   = 3'd0;
            end else begin
              rdr_d = rdr_q - 3'd1;
            end
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (!mem_wait) begin
            state_d = S_RUN;
            wait_d  = 8'd0;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            if (wait_q >= WAIT_LIMIT) begin
              timeout_set = 1'b1;
              state_d     = S_RUN;
              wait_d      = 8'd0;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = S_RUN;
          rdr_d   = 3'd0;
          wait_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      rdr_q        <= 3'd0;
      wait_q       <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_q <= state_d;
      rdr_q   <= rdr_d;
      wait_q  <= wait_d;
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (cnt_clear) begin
        stall_cycles <= '0;
        flush_events <= '0;
      end else begin
        if (pc_stall && (stall_cycles != CNT_MAX))
          stall_cycles <= stall_cycles + 1'b1;
        if (flush_inc && (flush_events != CNT_MAX))
          flush_events <= flush_events + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer; strobes are checked as a packed
// {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall} vector.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b110010;
  localparam logic [5:0] S_RED  = 6'b001010;
  localparam logic [5:0] S_RFL  = 6'b001000;
  localparam logic [5:0] S_MW   = 6'b110101;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic use_rs1_id, use_rs2_id, memread_ex, redirect_ex;
  logic dmem_req, dmem_ready, cnt_clear;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_sequencer #(
    .REDIRECT_CYCLES(1),
    .MEM_TIMEOUT    (4),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .use_rs1_id  (use_rs1_id),
    .use_rs2_id  (use_rs2_id),
    .rd_ex       (rd_ex),
    .memread_ex  (memread_ex),
    .redirect_ex (redirect_ex),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .cnt_clear   (cnt_clear),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_stall  (idex_stall),
    .idex_flush  (idex_flush),
    .exmem_stall (exmem_stall),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strb();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
  endfunction

  // Advance one clock; inputs change 1 after the edge, checks happen 4 after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; memread_ex = 1'b0;
    redirect_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_lu();
    memread_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    redirect_ex = 1'b1;
    dmem_req = 1'b1;
    #2;
    settle();
    chk("strobes_in_rst", 16'(strb()), 16'(S_NONE));
    next_cycle();
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    settle();
    chk("reset_strobes", 16'(strb()), 16'(S_NONE));
    chk("reset_timeout", 16'(mem_timeout), 16'd0);
    chk("reset_stall_cnt", 16'(stall_cycles), 16'd0);
    chk("reset_flush_cnt", 16'(flush_events), 16'd0);

    // load-use on rs2 -> single bubble
    next_cycle(); set_lu(); settle();
    chk("lu_rs2", 16'(strb()), 16'(S_LU));
    next_cycle(); memread_ex = 1'b0; settle();
    chk("lu_cleared", 16'(strb()), 16'(S_NONE));
    chk("lu_stall_cnt", 16'(stall_cycles), 16'd1);

    // rd_ex = x0 never hazards
    next_cycle(); idle_inputs(); memread_ex = 1'b1; use_rs1_id = 1'b1; settle();
    chk("lu_rd_x0", 16'(strb()), 16'(S_NONE));
    // matching rs2 but not used
    next_cycle(); set_lu(); use_rs2_id = 1'b0; rs1_id = 5'd3; use_rs1_id = 1'b1; settle();
    chk("lu_rs2_unused", 16'(strb()), 16'(S_NONE));
    // rs1 match
    next_cycle(); idle_inputs(); memread_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b1; settle();
    chk("lu_rs1", 16'(strb()), 16'(S_LU));
    next_cycle(); idle_inputs(); settle();
    chk("lu_rs1_stall_cnt", 16'(stall_cycles), 16'd2);

    // redirect pulse with one extra flush cycle
    next_cycle(); redirect_ex = 1'b1; settle();
    chk("redir_c0", 16'(strb()), 16'(S_RED));
    next_cycle(); redirect_ex = 1'b0; settle();
    chk("redir_c1", 16'(strb()), 16'(S_RFL));
    next_cycle(); settle();
    chk("redir_c2", 16'(strb()), 16'(S_NONE));
    chk("redir_flush_cnt", 16'(flush_events), 16'd1);

    // clear, then a 3-cycle memory wait
    next_cycle(); cnt_clear = 1'b1;
    next_cycle(); cnt_clear = 1'b0; settle();
    chk("clr_stall_cnt", 16'(stall_cycles), 16'd0);
    chk("clr_flush_cnt", 16'(flush_events), 16'd0);
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mw_c%0d", i), 16'(strb()), 16'(S_MW));
      next_cycle();
    end
    dmem_ready = 1'b1; settle();
    chk("mw_ready", 16'(strb()), 16'(S_NONE));
    next_cycle(); dmem_req = 1'b0; dmem_ready = 1'b0; settle();
    chk("mw_after", 16'(strb()), 16'(S_NONE));
    chk("mw_stall_cnt", 16'(stall_cycles), 16'd3);

    // same wait with a concurrent redirect and load-use held in EX/ID
    next_cycle(); dmem_req = 1'b1; redirect_ex = 1'b1; set_lu();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mwr_c%0d", i), 16'(strb()), 16'(S_MW));
      next_cycle();
    end
    dmem_ready = 1'b1; settle();
    chk("mwr_ready", 16'(strb()), 16'(S_NONE));
    chk("mwr_no_flush_yet", 16'(flush_events), 16'd0);
    next_cycle(); dmem_req = 1'b0; dmem_ready = 1'b0; settle();
    chk("mwr_redirect", 16'(strb()), 16'(S_RED));
    next_cycle(); idle_inputs(); settle();
    chk("mwr_redir_tail", 16'(strb()), 16'(S_RFL));
    chk("mwr_flush_cnt", 16'(flush_events), 16'd1);
    chk("mwr_stall_cnt", 16'(stall_cycles), 16'd6);

    // timeout: MEM_TIMEOUT=4, ready never comes
    next_cycle(); dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("to_stall_c%0d", i), 16'(strb()), 16'(S_MW));
      chk($sformatf("to_flag_c%0d", i), 16'(mem_timeout), 16'd0);
      next_cycle();
    end
    // back in RUN: a redirect is honoured (it would be ignored in MEM_WAIT)
    dmem_ready = 1'b1; redirect_ex = 1'b1; settle();
    chk("to_flag_set", 16'(mem_timeout), 16'd1);
    chk("to_back_in_run", 16'(strb()), 16'(S_RED));
    next_cycle(); idle_inputs(); settle();
    chk("to_redir_tail", 16'(strb()), 16'(S_RFL));
    next_cycle(); dmem_req = 1'b1; settle();
    chk("to_flag_sticky", 16'(mem_timeout), 16'd1);
    chk("rst_mw_c0", 16'(strb()), 16'(S_MW));
    next_cycle(); settle();
    chk("rst_mw_c1", 16'(strb()), 16'(S_MW));
    next_cycle(); rst = 1'b1; settle();
    chk("rst_mw_strobes", 16'(strb()), 16'(S_NONE));
    next_cycle(); rst = 1'b0; dmem_req = 1'b0; settle();
    chk("rst_after_strobes", 16'(strb()), 16'(S_NONE));
    chk("rst_after_flag", 16'(mem_timeout), 16'd0);
    chk("rst_after_stall_cnt", 16'(stall_cycles), 16'd0);

    // saturation at 15 with CNT_W=4
    set_lu();
    for (int i = 0; i < 20; i++) next_cycle();
    settle();
    chk("sat_strobes", 16'(strb()), 16'(S_LU));
    chk("sat_stall_cnt", 16'(stall_cycles), 16'd15);
    next_cycle(); cnt_clear = 1'b1;
    next_cycle(); cnt_clear = 1'b0; settle();
    chk("clr_wins", 16'(stall_cycles), 16'd0);
    next_cycle(); idle_inputs(); settle();
    chk("clr_then_count", 16'(stall_cycles), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control unit that sequences the IF/ID and ID/EX pipeline registers and the PC.
- Generates per-stage stall and flush strobes for three hazard classes:
  - load-use data hazards
  - control redirects (taken branch, jal, jalr) resolved in EX
  - multi-cycle data-memory waits
- Sits beside the decode stage. It replaces ad-hoc stall/flush decoding with one registered FSM plus saturating performance counters.

Parameters:
- REDIRECT_CYCLES, 1: extra cycles after a redirect during which IF/ID stays flushed (covers instruction-memory fetch latency). Legal range 0..7.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before the timeout error is raised. Must be at least 1.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rs1_id  in  5  rs1 of instruction in ID
- rs2_id  in  5  rs2 of instruction in ID
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rd_ex  in  5  destination register in EX
- memread_ex  in  1  EX instruction is a load
- redirect_ex  in  1  taken branch, jal or jalr resolved in EX this cycle
- dmem_req  in  1  MEM stage has an access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- cnt_clear  in  1  synchronous clear of performance counters
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  load bubble into ID/EX (control bits 0, instruction 0x00000013)
- exmem_stall  out  1  hold EX/MEM and MEM/WB
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  cycles with pc_stall=1
- flush_events  out  CNT_W  redirect events accepted

Behaviour:
- FSM states: RUN, REDIRECT, MEM_WAIT. State register, redirect counter (3 bit) and wait counter (8 bit) are all cleared on rst.
- Strobe outputs are Mealy: a function of state plus current inputs, with no input-to-output latency.
- Reset values:
  - all strobes 0
  - mem_timeout 0
  - counters 0
  - state RUN
- rst mid-operation aborts any state to RUN on the next edge. While rst=1, all strobes are 0.
- Load-use hazard condition (load_use): memread_ex && rd_ex!=0 && ((use_rs1_id && rs1_id==rd_ex) || (use_rs2_id && rs2_id==rd_ex)).
- Priority within RUN is mem_wait > redirect > load_use. mem_wait means dmem_req && !dmem_ready.
- RUN, mem_wait:
  - pc_stall, ifid_stall, idex_stall and exmem_stall all 1; no flushes
  - next state MEM_WAIT; wait counter set to 1
- RUN, redirect_ex:
  - ifid_flush=1, idex_flush=1, stalls 0
  - flush_events increments
  - if REDIRECT_CYCLES>0: next state REDIRECT, counter = REDIRECT_CYCLES; otherwise stay in RUN
- RUN, load_use:
  - pc_stall=1, ifid_stall=1, idex_flush=1 (one bubble); stay in RUN
  - after the bubble, memread_ex is 0, so the hazard clears automatically
- RUN, no hazard: all strobes 0.
- REDIRECT:
  - ifid_flush=1; counter decrements each cycle; return to RUN when the counter reaches 1 (at the same edge it is consumed)
  - mem_wait in REDIRECT takes priority: behaves as in RUN and moves to MEM_WAIT; the remaining redirect count is discarded
  - a new redirect_ex in REDIRECT reloads the counter and increments flush_events
- MEM_WAIT:
  - all four stalls stay 1 while dmem_ready=0; wait counter increments
  - when dmem_ready=1, strobes drop that same cycle and the next state is RUN
  - a redirect_ex held in EX during the wait is re-evaluated in RUN after exit; no redirect is lost
- Timeout: if the wait counter reaches MEM_TIMEOUT with dmem_ready=0:
  - mem_timeout is set and stays set until rst
  - FSM returns to RUN
- Flush/stall conflict: idex_flush and idex_stall are never both 1. ifid_flush and ifid_stall are never both 1.
- Counters:
  - stall_cycles counts cycles with pc_stall=1; flush_events as defined above
  - both saturate at 2^CNT_W-1
  - cnt_clear zeroes both and wins over a same-cycle increment

Test Plan:
- Load x5 in EX (memread_ex=1, rd_ex=5), ID uses rs2=5 -> exactly one cycle of pc_stall=ifid_stall=idex_flush=1; next cycle (memread_ex=0) all strobes 0; stall_cycles=1.
- Same pattern with rd_ex=0, or with use_rs2_id=0 -> no strobes asserted.
- redirect_ex pulse, REDIRECT_CYCLES=1 -> cycle 0: ifid_flush=idex_flush=1; cycle 1: ifid_flush=1 only; cycle 2: all 0; flush_events=1.
- dmem_req=1 with dmem_ready low for 3 cycles then high -> all stalls 1 for 3 cycles, 0 in the ready cycle; stall_cycles=3. Repeat with a concurrent redirect_ex and load_use: stalls only, redirect flush occurs the cycle after exit.
- dmem_ready held 0 with MEM_TIMEOUT=4 -> mem_timeout sets after 4 wait cycles, FSM returns to RUN, flag stays 1; rst asserted in MEM_WAIT -> all outputs 0 next cycle.
- Force stall_cycles to saturate with CNT_W=4 -> holds at 15; cnt_clear concurrent with a stall -> reads 0.
